// File: rtl/serial_mag_comparator_pkg.sv
// Shared definitions for the serial magnitude comparator.
// Holds the FSM state encoding, the default operand width and the
// index constants used to address the gt/eq/lt flag vector.
package serial_mag_comparator_pkg;

  // FSM states: idle waiting for start, or shifting one bit per clock.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Default operand width.
  localparam int DEFAULT_WIDTH = 8;

  // Positions of the relation flags inside the packed flag vector.
  localparam int GT = 2;
  localparam int EQ = 1;
  localparam int LT = 0;

endpackage

// File: rtl/serial_mag_comparator_bit_cmp_cell.sv
// Purpose : combinational 1-bit magnitude compare of x against y.
// Latency : none, purely combinational.
// Backpressure: none; output follows inputs.
// Ports   : x, y            - bits under comparison
//           x_gt/x_eq/x_lt  - exactly one is high for any input pair
module bit_cmp_cell (
  input  logic x,
  input  logic y,
  output logic x_gt,
  output logic x_eq,
  output logic x_lt
);

  assign x_gt = x & ~y;
  assign x_eq = ~(x ^ y);
  assign x_lt = ~x & y;

endmodule

// File: rtl/serial_mag_comparator.sv
// Purpose : multi-cycle unsigned magnitude comparator, MSB first, one bit
//           per clock through a single bit_cmp_cell.
// Latency : WIDTH cycles from the accepted start edge to the done edge;
//           with EARLY_EXIT_EN defined, 1..WIDTH (ends on the first
//           differing bit; equal operands still take WIDTH).
// Backpressure: start is only sampled in IDLE; start while busy is dropped.
// Ports   : clk, rst (async, active-high)
//           start, a, b     - request and operands, captured when idle
//           busy            - comparison in progress
//           done            - one-cycle pulse, flags valid from this cycle
//           gt, eq, lt      - registered one-hot result, held until the
//                             next accepted start or reset
// Config  : `define EARLY_EXIT_EN to finish on the first differing bit.
module serial_mag_comparator
  import serial_mag_comparator_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dec_q, dec_d;       // a differing bit has been seen
  logic             rel_gt_q, rel_gt_d; // relation at the first differing bit
  logic [2:0]       flags_q, flags_d;
  logic             done_q, done_d;

  logic bit_gt, bit_eq, bit_lt;
  logic new_diff;
  logic finish;
  logic res_dec, res_gt, res_lt;

  // Single comparator cell always looks at the current MSBs.
  bit_cmp_cell u_cell (
    .x    (sa_q[WIDTH-1]),
    .y    (sb_q[WIDTH-1]),
    .x_gt (bit_gt),
    .x_eq (bit_eq),
    .x_lt (bit_lt)
  );

  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    cnt_d    = cnt_q;
    dec_d    = dec_q;
    rel_gt_d = rel_gt_q;
    flags_d  = flags_q;
    done_d   = 1'b0;

    // First difference only; later bits never override a decided relation.
    new_diff = ~dec_q & ~bit_eq;

    // Relation including the bit being compared on this edge, so the LSB
    // (compared on the final edge) is accounted for.
    res_dec  = dec_q | ~bit_eq;
    res_gt   = dec_q ? rel_gt_q  : bit_gt;
    res_lt   = dec_q ? ~rel_gt_q : bit_lt;

`ifdef EARLY_EXIT_EN
    finish   = (cnt_q == '0) | new_diff;
`else
    finish   = (cnt_q == '0);
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sa_d     = a;
          sb_d     = b;
          cnt_d    = CW'(WIDTH - 1);
          dec_d    = 1'b0;
          rel_gt_d = 1'b0;
          flags_d  = '0;
          state_d  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (new_diff) begin
          dec_d    = 1'b1;
          rel_gt_d = bit_gt;
        end
        sa_d  = {sa_q[WIDTH-2:0], 1'b0};
        sb_d  = {sb_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q - 1'b1;
        if (finish) begin
          flags_d[GT] = res_dec & res_gt;
          flags_d[EQ] = ~res_dec;
          flags_d[LT] = res_dec & res_lt;
          done_d      = 1'b1;
          cnt_d       = '0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      cnt_q    <= '0;
      dec_q    <= 1'b0;
      rel_gt_q <= 1'b0;
      flags_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      cnt_q    <= cnt_d;
      dec_q    <= dec_d;
      rel_gt_q <= rel_gt_d;
      flags_q  <= flags_d;
      done_q   <= done_d;
    end
  end

  assign busy = (state_q == ST_SHIFT);
  assign done = done_q;
  assign gt   = flags_q[GT];
  assign eq   = flags_q[EQ];
  assign lt   = flags_q[LT];

endmodule

// File: tb/tb_serial_mag_comparator.sv
module tb_serial_mag_comparator;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy, done, gt, eq, lt;

  int checks = 0;
  int errors = 0;

  serial_mag_comparator #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .gt    (gt),
    .eq    (eq),
    .lt    (lt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycles from accepted start to done for a given operand pair.
  function automatic int exp_lat(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef EARLY_EXIT_EN
    for (int i = W - 1; i >= 0; i--)
      if (x[i] != y[i]) return W - i;
`endif
    return W;
  endfunction

  // ---------------- reference model (transaction level) ----------------
  logic m_busy, m_done, m_gt, m_eq, m_lt;
  logic r_gt, r_eq, r_lt;
  int   m_left;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0; m_done <= 1'b0;
      m_gt <= 1'b0; m_eq <= 1'b0; m_lt <= 1'b0;
      m_left <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          m_gt <= r_gt; m_eq <= r_eq; m_lt <= r_lt;
        end
      end else if (start) begin
        m_busy <= 1'b1;
        m_gt <= 1'b0; m_eq <= 1'b0; m_lt <= 1'b0;
        r_gt <= (a > b); r_eq <= (a == b); r_lt <= (a < b);
        m_left <= exp_lat(a, b);
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    checks++;
    if ({busy, done, gt, eq, lt} !== {m_busy, m_done, m_gt, m_eq, m_lt}) begin
      errors++;
      $display("FAIL cycle_check t=%0t dut busy/done/gt/eq/lt=%b%b%b%b%b model=%b%b%b%b%b",
               $time, busy, done, gt, eq, lt, m_busy, m_done, m_gt, m_eq, m_lt);
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Called at a negedge with start already driven; returns cycles from
  // the accepting edge to the done edge.
  task automatic wait_done(input bit drop_start, output int lat);
    int cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1 && drop_start) start = 1'b0;
    end while (!done && cyc < 40);
    if (!done) check("done_timeout", 0, 1);
    lat = cyc - 1;
  endtask

  task automatic run(input string name, input logic [W-1:0] va, input logic [W-1:0] vb,
                     input int elat, input logic [2:0] eflags);
    int lat;
    start = 1'b1; a = va; b = vb;
    wait_done(1'b1, lat);
    check({name, "_lat"}, lat, elat);
    check({name, "_flags"}, int'({gt, eq, lt}), int'(eflags));
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int lat;
    int cyc;
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("reset_state", int'({busy, done, gt, eq, lt}), 0);
    rst = 1'b0;
    @(negedge clk);

    // Equal operands: full length, eq, flags hold afterwards.
    run("equal", 8'hA5, 8'hA5, 8, 3'b010);
    repeat (3) @(negedge clk);
    check("equal_hold", int'({busy, gt, eq, lt}), 4'b0010);

    // MSB difference.
`ifdef EARLY_EXIT_EN
    run("msb_diff", 8'h80, 8'h7F, 1, 3'b100);
`else
    run("msb_diff", 8'h80, 8'h7F, 8, 3'b100);
`endif
    @(negedge clk);

    // LSB difference: full length in both builds.
    run("lsb_diff", 8'h3C, 8'h3D, 8, 3'b001);
    @(negedge clk);

    // Mid-SHIFT asynchronous reset.
    start = 1'b1; a = 8'hFF; b = 8'h00;
    @(negedge clk); start = 1'b0;
    check("busy_before_rst", int'(busy), 1);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1 check("async_reset", int'({busy, done, gt, eq, lt}), 0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
`ifdef EARLY_EXIT_EN
    run("after_rst", 8'h10, 8'h20, 3, 3'b001);
`else
    run("after_rst", 8'h10, 8'h20, 8, 3'b001);
`endif
    @(negedge clk);

    // Start re-pulsed while busy is ignored.
    start = 1'b1; a = 8'hFF; b = 8'h00;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) start = 1'b0;
      if (cyc == 3) begin start = 1'b1; a = 8'h00; b = 8'hFF; end
      if (cyc == 4) start = 1'b0;
    end while (!done && cyc < 40);
    start = 1'b0;
`ifdef EARLY_EXIT_EN
    check("busy_ignore_lat", cyc - 1, 1);
`else
    check("busy_ignore_lat", cyc - 1, 8);
`endif
    check("busy_ignore_flags", int'({gt, eq, lt}), 3'b100);

    // Start in the done cycle is accepted (after the ignored re-pulse
    // completes any pending work in the early-exit build).
    repeat (12) @(negedge clk);
    run("pre_done", 8'h11, 8'h11, 8, 3'b010);
    run("in_done", 8'h3C, 8'h3D, 8, 3'b001);

    // Start held high: done every WIDTH+1 cycles.
    start = 1'b1; a = 8'h55; b = 8'h55;
    wait_done(1'b0, lat);
    for (int n = 0; n < 2; n++) begin
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
      end while (!done && cyc < 40);
      check("held_period", cyc, 9);
    end
    start = 1'b0;
    cyc = 0;
    while (busy && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("idle_at_end", int'(busy), 0);
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
